data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 155 +++++++++++++++
 tb/tb_data_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for a cache: 64-bit word array with write-first forwarding,
// a programmable read latency and a registered response interface.
module data_mem_responder #(
  parameter int unsigned ADDR_LSB     = 2,
  parameter int unsigned DEPTH_LOG2   = 10,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mrden,
  input  logic [31:0] m_rd_address,
  input  logic        mwren,
  input  logic [31:0] m_wr_address,
  input  logic [63:0] data2mem,
  output logic [63:0] data_in_mem,
  output logic        rd_valid,
  output logic        busy,
  output logic        err
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned HI_LSB = ADDR_LSB + DEPTH_LOG2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam bit MULTI_CYCLE = (READ_LATENCY > 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]       pend_q, pend_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic [DATA_W-1:0]       mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0]   rd_idx_c, wr_idx_c;
  logic                    rd_oor_c, wr_oor_c;
  logic                    wr_en_c;
  logic [DATA_W-1:0]       rd_word_c;
  logic                    accept_c, drop_c;
  logic                    unused_offset_c;

  // Byte-offset bits never select anything.
  assign unused_offset_c = ^{m_rd_address[ADDR_LSB-1:0], m_wr_address[ADDR_LSB-1:0]};

  // Address decode and write-first read word.
  always_comb begin
    rd_idx_c = m_rd_address[ADDR_LSB +: DEPTH_LOG2];
    wr_idx_c = m_wr_address[ADDR_LSB +: DEPTH_LOG2];
    rd_oor_c = |(m_rd_address >> HI_LSB);
    wr_oor_c = |(m_wr_address >> HI_LSB);
    wr_en_c  = mwren & ~wr_oor_c & ~rst;
    if (rd_oor_c) begin
      rd_word_c = '0;
    end else if (wr_en_c && (wr_idx_c == rd_idx_c)) begin
      rd_word_c = data2mem;
    end else begin
      rd_word_c = mem_q[rd_idx_c];
    end
  end

  // Read-response FSM: next state, counter, snapshot and registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    data_d     = data_q;
    accept_c   = 1'b0;
    drop_c     = 1'b0;
    rd_valid_d = 1'b0;
    busy_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        accept_c = mrden;
      end
      WAIT: begin
        drop_c = mrden;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RESP;
          data_d  = pend_q;
        end
      end
      RESP: begin
        state_d = IDLE;
        // With multi-cycle latency RESP is still a busy cycle.
        if (MULTI_CYCLE) begin
          drop_c = mrden;
        end else begin
          accept_c = mrden;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept_c) begin
      pend_d = rd_word_c;
      cnt_d  = CNT_LOAD;
      if (MULTI_CYCLE) begin
        state_d = WAIT;
      end else begin
        state_d = RESP;
        data_d  = rd_word_c;
      end
    end

    rd_valid_d = (state_d == RESP);
    busy_d     = (state_d == WAIT) || ((state_d == RESP) && MULTI_CYCLE);
    err_d      = drop_c | (accept_c & rd_oor_c) | (mwren & wr_oor_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      data_q     <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Storage array is not reset; writes never stall.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_q[wr_idx_c] <= data2mem;
    end
  end

  assign data_in_mem = data_q;
  assign rd_valid    = rd_valid_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three latency variants checked against a
// cycle-timestamp reference model, plus directed vector tables and corner sequences.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i   [3];
  logic        mrden_i [3];
  logic        mwren_i [3];
  logic [31:0] rda_i   [3];
  logic [31:0] wra_i   [3];
  logic [63:0] wd_i    [3];
  logic [63:0] dout    [3];
  logic        vld     [3];
  logic        bsy     [3];
  logic        er      [3];

  data_mem_responder #(.READ_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst_i[0]), .mrden(mrden_i[0]), .m_rd_address(rda_i[0]),
    .mwren(mwren_i[0]), .m_wr_address(wra_i[0]), .data2mem(wd_i[0]),
    .data_in_mem(dout[0]), .rd_valid(vld[0]), .busy(bsy[0]), .err(er[0]));

  data_mem_responder #(.READ_LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst_i[1]), .mrden(mrden_i[1]), .m_rd_address(rda_i[1]),
    .mwren(mwren_i[1]), .m_wr_address(wra_i[1]), .data2mem(wd_i[1]),
    .data_in_mem(dout[1]), .rd_valid(vld[1]), .busy(bsy[1]), .err(er[1]));

  data_mem_responder #(.READ_LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst_i[2]), .mrden(mrden_i[2]), .m_rd_address(rda_i[2]),
    .mwren(mwren_i[2]), .m_wr_address(wra_i[2]), .data2mem(wd_i[2]),
    .data_in_mem(dout[2]), .rd_valid(vld[2]), .busy(bsy[2]), .err(er[2]));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: timestamps of the last accepted read and its response cycle.
  logic [63:0] ref_mem [3][1024];
  bit          ref_wr  [3][1024];
  int          acc_c   [3];
  int          resp_c  [3];
  logic [63:0] pend_x  [3];
  bit          pend_ok [3];
  logic [63:0] data_x  [3];
  bit          data_ok [3];
  bit          err_x   [3];
  bit          exp_v   [3];
  bit          exp_b   [3];

  typedef struct {
    bit          mwren;
    logic [31:0] wa;
    logic [63:0] wd;
    bit          mrden;
    logic [31:0] ra;
    bit          ev;
    logic [63:0] ed;
    bit          ee;
  } vec_t;

  vec_t tbl [10];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic vec_t mk(input bit w, input logic [31:0] wa, input logic [63:0] wd,
                              input bit r, input logic [31:0] ra,
                              input bit ev, input logic [63:0] ed, input bit ee);
    vec_t v;
    v.mwren = w; v.wa = wa; v.wd = wd; v.mrden = r; v.ra = ra;
    v.ev = ev; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic model_step(input int k);
    int  c;
    int  ri;
    int  wi;
    bit  rd_oor;
    bit  wr_oor;
    bit  wr_ok;
    bit  busy_now;
    bit  e;
    c      = cyc;
    ri     = int'(rda_i[k][11:2]);
    wi     = int'(wra_i[k][11:2]);
    rd_oor = (rda_i[k] >> 12) != 32'd0;
    wr_oor = (wra_i[k] >> 12) != 32'd0;
    if (rst_i[k]) begin
      acc_c[k]   = -100;
      resp_c[k]  = -1;
      data_x[k]  = 64'h0;
      data_ok[k] = 1'b1;
      err_x[k]   = 1'b0;
    end else begin
      busy_now = (lat_of(k) > 1) && (acc_c[k] < c) && (c <= resp_c[k]);
      wr_ok    = mwren_i[k] && !wr_oor;
      e        = mwren_i[k] && wr_oor;
      if (mrden_i[k]) begin
        if (busy_now) begin
          e = 1'b1;
        end else begin
          acc_c[k]  = c;
          resp_c[k] = c + lat_of(k);
          if (rd_oor) begin
            pend_x[k] = 64'h0; pend_ok[k] = 1'b1; e = 1'b1;
          end else if (wr_ok && wi == ri) begin
            pend_x[k] = wd_i[k]; pend_ok[k] = 1'b1;
          end else begin
            pend_x[k] = ref_mem[k][ri]; pend_ok[k] = ref_wr[k][ri];
          end
        end
      end
      if (wr_ok) begin
        ref_mem[k][wi] = wd_i[k];
        ref_wr[k][wi]  = 1'b1;
      end
      err_x[k] = e;
      if (resp_c[k] == c + 1) begin
        data_x[k]  = pend_x[k];
        data_ok[k] = pend_ok[k];
      end
    end
    exp_v[k] = (resp_c[k] == c + 1);
    exp_b[k] = (lat_of(k) > 1) && (acc_c[k] < c + 1) && (c + 1 <= resp_c[k]);
  endtask

  // Apply the current inputs for one cycle, compare against the model, then idle inputs.
  task automatic tick();
    for (int k = 0; k < 3; k++) model_step(k);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("model_valid m%0d c%0d", k, cyc), 64'(vld[k]), 64'(exp_v[k]));
      check($sformatf("model_busy m%0d c%0d", k, cyc), 64'(bsy[k]), 64'(exp_b[k]));
      check($sformatf("model_err m%0d c%0d", k, cyc), 64'(er[k]), 64'(err_x[k]));
      if (data_ok[k])
        check($sformatf("model_data m%0d c%0d", k, cyc), dout[k], data_x[k]);
    end
    for (int k = 0; k < 3; k++) begin
      rst_i[k] = 1'b0; mrden_i[k] = 1'b0; mwren_i[k] = 1'b0;
    end
  endtask

  task automatic expect_ctl(input string tag, input int k, input bit v, input bit b, input bit e);
    check({tag, "_valid"}, 64'(vld[k]), 64'(v));
    check({tag, "_busy"}, 64'(bsy[k]), 64'(b));
    check({tag, "_err"}, 64'(er[k]), 64'(e));
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [63:0] d);
    mwren_i[k] = 1'b1; wra_i[k] = a; wd_i[k] = d;
  endtask

  task automatic rd(input int k, input logic [31:0] a);
    mrden_i[k] = 1'b1; rda_i[k] = a;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_i[k] = 1'b1; mrden_i[k] = 1'b0; mwren_i[k] = 1'b0;
      rda_i[k] = '0; wra_i[k] = '0; wd_i[k] = '0;
      acc_c[k] = -100; resp_c[k] = -1; data_x[k] = '0; data_ok[k] = 1'b1;
      pend_x[k] = '0; pend_ok[k] = 1'b1; err_x[k] = 1'b0;
      for (int i = 0; i < 1024; i++) begin ref_mem[k][i] = '0; ref_wr[k][i] = 1'b0; end
    end

    tbl[0] = mk(1, 32'h10, 64'h0123_4567_89AB_CDEF, 0, 32'h0, 0, 64'h0, 0);
    tbl[1] = mk(0, 32'h0, 64'h0, 1, 32'h13, 1, 64'h0123_4567_89AB_CDEF, 0);
    tbl[2] = mk(0, 32'h0, 64'h0, 0, 32'h0, 0, 64'h0123_4567_89AB_CDEF, 0);
    tbl[3] = mk(1, 32'h40, 64'hDEAD_BEEF, 1, 32'h40, 1, 64'hDEAD_BEEF, 0);
    tbl[4] = mk(1, 32'h48, 64'h77, 1, 32'h10, 1, 64'h0123_4567_89AB_CDEF, 0);
    tbl[5] = mk(0, 32'h0, 64'h0, 1, 32'h48, 1, 64'h77, 0);
    tbl[6] = mk(0, 32'h0, 64'h0, 1, 32'h0001_0000, 1, 64'h0, 1);
    tbl[7] = mk(1, 32'h0, 64'h55, 0, 32'h0, 0, 64'h0, 0);
    tbl[8] = mk(1, 32'h0001_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 32'h0, 0, 64'h0, 1);
    tbl[9] = mk(0, 32'h0, 64'h0, 1, 32'h0, 1, 64'h55, 0);

    // Reset state.
    for (int k = 0; k < 3; k++) rst_i[k] = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) rst_i[k] = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      expect_ctl($sformatf("reset m%0d", k), k, 0, 0, 0);
      check($sformatf("reset_data m%0d", k), dout[k], 64'h0);
    end

    // Single-cycle vectors on the latency-1 instance.
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].mwren) wr(0, tbl[i].wa, tbl[i].wd);
      if (tbl[i].mrden) rd(0, tbl[i].ra);
      tick();
      expect_ctl($sformatf("tbl%0d", i), 0, tbl[i].ev, 1'b0, tbl[i].ee);
      check($sformatf("tbl%0d_data", i), dout[0], tbl[i].ed);
    end

    // Back-to-back reads with latency 1.
    for (int i = 0; i < 4; i++) begin
      wr(0, 32'(i * 4), 64'hA000 + 64'(i));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      rd(0, 32'(i * 4));
      tick();
      expect_ctl($sformatf("b2b%0d", i), 0, 1, 0, 0);
      check($sformatf("b2b%0d_data", i), dout[0], 64'hA000 + 64'(i));
    end
    tick();
    expect_ctl("b2b_end", 0, 0, 0, 0);
    check("b2b_end_data", dout[0], 64'hA003);

    // Latency 4: busy window, dropped read mid-flight.
    wr(2, 32'h20, 64'hC0FF_EE00_1234_5678);
    tick();
    rd(2, 32'h20);
    tick();
    expect_ctl("lat4_t1", 2, 0, 1, 0);
    tick();
    expect_ctl("lat4_t2", 2, 0, 1, 0);
    rd(2, 32'h24);
    tick();
    expect_ctl("lat4_t3", 2, 0, 1, 1);
    tick();
    expect_ctl("lat4_t4", 2, 1, 1, 0);
    check("lat4_t4_data", dout[2], 64'hC0FF_EE00_1234_5678);
    for (int i = 5; i <= 8; i++) begin
      tick();
      expect_ctl($sformatf("lat4_t%0d", i), 2, 0, 0, 0);
      check($sformatf("lat4_t%0d_data", i), dout[2], 64'hC0FF_EE00_1234_5678);
    end

    // Latency 3: forwarding and snapshot isolation from later writes.
    wr(1, 32'h40, 64'hDEAD_BEEF);
    rd(1, 32'h40);
    tick();
    wr(1, 32'h40, 64'h1);
    tick();
    expect_ctl("snap_t2", 1, 0, 1, 0);
    tick();
    expect_ctl("snap_t3", 1, 1, 1, 0);
    check("snap_t3_data", dout[1], 64'hDEAD_BEEF);
    tick();
    rd(1, 32'h40);
    tick(); tick(); tick();
    expect_ctl("reread", 1, 1, 1, 0);
    check("reread_data", dout[1], 64'h1);

    // Latency 3: reset one cycle after accept abandons the read.
    tick();
    wr(1, 32'h50, 64'hABCD);
    tick();
    rd(1, 32'h50);
    tick();
    rst_i[1] = 1'b1;
    tick();
    expect_ctl("rstmid_t2", 1, 0, 0, 0);
    check("rstmid_t2_data", dout[1], 64'h0);
    for (int i = 3; i <= 5; i++) begin
      tick();
      expect_ctl($sformatf("rstmid_t%0d", i), 1, 0, 0, 0);
    end
    rd(1, 32'h50);
    tick(); tick(); tick();
    expect_ctl("rstmid_fresh", 1, 1, 1, 0);
    check("rstmid_fresh_data", dout[1], 64'hABCD);
    tick();

    // Fill a small window so random reads return defined data.
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 3; k++) wr(k, 32'(i * 4), {$urandom, $urandom});
      tick();
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      for (int k = 0; k < 3; k++) begin
        rst_i[k]   = ($urandom_range(0, 99) == 0);
        mrden_i[k] = $urandom_range(0, 1) == 1;
        mwren_i[k] = $urandom_range(0, 9) < 4;
        rda_i[k]   = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        wra_i[k]   = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        wd_i[k]    = {$urandom, $urandom};
        if ($urandom_range(0, 19) == 0) rda_i[k] = rda_i[k] | (32'h1 << $urandom_range(12, 31));
        if ($urandom_range(0, 19) == 0) wra_i[k] = wra_i[k] | (32'h1 << $urandom_range(12, 31));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
